// File: rtl/bpu_bimodal_pkg.sv
// bpu_bimodal_pkg: shared fetch-stage definitions for the bimodal branch predictor.
// Holds the opcode constants, bus types and the counter reset helper used by
// bpu_bimodal, its interface and its counter sub-module.
package bpu_bimodal_pkg;

    typedef logic [31:0] inst_bus_t;
    typedef logic [31:0] inst_addr_bus_t;

    localparam logic [6:0]     INST_JAL    = 7'b1101111;
    localparam logic [6:0]     INST_TYPE_B = 7'b1100011;
    localparam logic           JumpDisable = 1'b0;
    localparam inst_addr_bus_t ZeroWord    = 32'h0000_0000;

    // Weakly-not-taken starting value: one below the taken threshold (0 for 1-bit counters).
    function automatic int BPU_CNT_TAKEN_INIT(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/bpu_bimodal_if.sv
// bpu_bimodal_if: fetch-side prediction and EX-side training signals of the
// branch predictor. master = pipeline side, slave = predictor side.
interface bpu_bimodal_if #(
    parameter int IDX_W = 6
);
    import bpu_bimodal_pkg::*;

    inst_bus_t       inst_i;
    inst_addr_bus_t  inst_addr_i;
    logic            bp_result_o;
    inst_addr_bus_t  bp_jump_addr_o;
    logic [IDX_W-1:0] bp_index_o;

    logic            upd_valid_i;
    logic [IDX_W-1:0] upd_index_i;
    logic            upd_taken_i;
    logic            upd_pred_i;

    logic [31:0]     perf_mispred_o;

    modport master (
        output inst_i, inst_addr_i,
        output upd_valid_i, upd_index_i, upd_taken_i, upd_pred_i,
        input  bp_result_o, bp_jump_addr_o, bp_index_o, perf_mispred_o
    );

    modport slave (
        input  inst_i, inst_addr_i,
        input  upd_valid_i, upd_index_i, upd_taken_i, upd_pred_i,
        output bp_result_o, bp_jump_addr_o, bp_index_o, perf_mispred_o
    );

endinterface

// File: rtl/bpu_bimodal_sat_counter.sv
// bpu_sat_counter: one CNT_W-bit up/down counter that sticks at 0 and at its
// maximum instead of wrapping. One instance per predictor table entry.
module bpu_sat_counter #(
    parameter int               CNT_W = 2,
    parameter logic [CNT_W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] MAX = '1;

    // Step toward taken or not-taken on each enabled update, saturating at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= INIT;
        end else if (en) begin
            if (inc) begin
                if (value != MAX) begin
                    value <= value + CNT_W'(1);
                end
            end else if (value != '0) begin
                value <= value - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bpu_bimodal.sv
// bpu_bimodal: PC-indexed table of saturating counters predicting conditional
// branches in IF, with static-taken JAL, target computation and a global
// misprediction counter. Defining BPU_GSHARE_EN XORs the index with a global
// history register built from resolved outcomes (gshare).
module bpu_bimodal
    import bpu_bimodal_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    bpu_bimodal_if.slave     bus
);

    localparam int               IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [CNT_W-1:0] TH       = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BPU_CNT_TAKEN_INIT(CNT_W));
    localparam logic [31:0]      PERF_MAX = '1;

    logic [CNT_W-1:0] cnt_val [ENTRIES];
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] idx;
    logic [6:0]       opcode;
    logic [31:0]      imm_j;
    logic [31:0]      imm_b;
    logic [31:0]      perf_q;
    logic             mispred;

    assign pc_idx = bus.inst_addr_i[IDX_W+1:2];

`ifdef BPU_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Shift each resolved outcome into the history; wrong-path fetches never touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (bus.upd_valid_i) begin
            ghr <= IDX_W'({ghr, bus.upd_taken_i});
        end
    end

    assign idx = pc_idx ^ ghr;
`else
    assign idx = pc_idx;
`endif

    assign bus.bp_index_o = idx;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        bpu_sat_counter #(
            .CNT_W (CNT_W),
            .INIT  (CNT_INIT)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .en    (bus.upd_valid_i && (bus.upd_index_i == IDX_W'(i))),
            .inc   (bus.upd_taken_i),
            .value (cnt_val[i])
        );
    end

    assign opcode = bus.inst_i[6:0];
    assign imm_j  = {{12{bus.inst_i[31]}}, bus.inst_i[19:12], bus.inst_i[20],
                     bus.inst_i[30:21], 1'b0};
    assign imm_b  = {{20{bus.inst_i[31]}}, bus.inst_i[7], bus.inst_i[30:25],
                     bus.inst_i[11:8], 1'b0};

    // Zero-latency prediction: JAL always jumps, B-type reads the (pre-update) counter.
    always_comb begin
        bus.bp_result_o    = JumpDisable;
        bus.bp_jump_addr_o = ZeroWord;
        case (opcode)
            INST_JAL: begin
                bus.bp_result_o    = 1'b1;
                bus.bp_jump_addr_o = bus.inst_addr_i + imm_j;
            end
            INST_TYPE_B: begin
                bus.bp_result_o    = (cnt_val[idx] >= TH);
                bus.bp_jump_addr_o = bus.inst_addr_i + imm_b;
            end
            default: begin
            end
        endcase
    end

    assign mispred = bus.upd_valid_i && (bus.upd_taken_i != bus.upd_pred_i);

    // Count resolved mispredictions, sticking at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (mispred && (perf_q != PERF_MAX)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_mispred_o = perf_q;

endmodule

// File: tb/tb_bpu_bimodal.sv
// tb_bpu_bimodal: directed self-checking bench for bpu_bimodal (ENTRIES=64, CNT_W=2).
// A vector table covers decode/target/index after reset; hand sequences cover
// training, saturation, same-cycle update, async reset and (with BPU_GSHARE_EN) history.
module tb_bpu_bimodal;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        exp_result;
        logic [31:0] exp_target;
        logic [5:0]  exp_index;
    } vec_t;

    vec_t vectors [8];

    bpu_bimodal_if #(.IDX_W(IDX_W)) bus ();

    bpu_bimodal #(
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop if the run ever overstays its budget.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] enc_b(input int off);
        logic [12:0] imm;
        imm = off[12:0];
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] imm;
        imm = off[20:0];
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] addr);
        @(negedge clk);
        bus.inst_i      = inst;
        bus.inst_addr_i = addr;
        #1;
    endtask

    task automatic check_output(input string name, input logic exp_result,
                                input logic [31:0] exp_target, input logic [5:0] exp_index);
        check_value({name, ".result"}, {31'd0, bus.bp_result_o}, {31'd0, exp_result});
        check_value({name, ".target"}, bus.bp_jump_addr_o, exp_target);
        check_value({name, ".index"}, {26'd0, bus.bp_index_o}, {26'd0, exp_index});
    endtask

    task automatic do_update(input logic [5:0] index, input logic taken, input logic pred);
        @(negedge clk);
        bus.upd_valid_i = 1'b1;
        bus.upd_index_i = index;
        bus.upd_taken_i = taken;
        bus.upd_pred_i  = pred;
        @(negedge clk);
        bus.upd_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.upd_valid_i = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.inst_i      = 32'h0000_0013;
        bus.inst_addr_i = 32'h0;
        bus.upd_valid_i = 1'b0;
        bus.upd_index_i = '0;
        bus.upd_taken_i = 1'b0;
        bus.upd_pred_i  = 1'b0;

        vectors[0] = '{enc_b(16),      32'h0000_0100, 1'b0, 32'h0000_0110, 6'h00};
        vectors[1] = '{enc_b(-8),      32'h0000_0100, 1'b0, 32'h0000_00F8, 6'h00};
        vectors[2] = '{enc_j(32),      32'hFFFF_FFF0, 1'b1, 32'h0000_0010, 6'h3C};
        vectors[3] = '{enc_j(-4),      32'h0000_1000, 1'b1, 32'h0000_0FFC, 6'h00};
        vectors[4] = '{32'h0010_0093,  32'h0000_0104, 1'b0, 32'h0000_0000, 6'h01};
        vectors[5] = '{enc_b(4),       32'h0000_00FC, 1'b0, 32'h0000_0100, 6'h3F};
        vectors[6] = '{enc_b(2048),    32'h0000_0200, 1'b0, 32'h0000_0A00, 6'h00};
        vectors[7] = '{enc_j(32'h12B46), 32'h0000_0000, 1'b1, 32'h0001_2B46, 6'h00};

        do_reset();
        #1;
        check_value("reset.perf", bus.perf_mispred_o, 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vectors[i].inst, vectors[i].addr);
            check_output($sformatf("vec%0d", i), vectors[i].exp_result,
                         vectors[i].exp_target, vectors[i].exp_index);
        end
        check_value("vec.perf_unchanged", bus.perf_mispred_o, 32'd0);
        apply_stimulus(enc_b(16), 32'h0000_0100);
        check_output("jal_table_untouched", 1'b0, 32'h0000_0110, 6'h00);

`ifndef BPU_GSHARE_EN
        // Training and saturation at index 0.
        do_reset();
        do_update(6'h00, 1'b1, 1'b0);
        apply_stimulus(enc_b(16), 32'h0000_0100);
        check_output("train.after1", 1'b1, 32'h0000_0110, 6'h00);
        check_value("train.perf1", bus.perf_mispred_o, 32'd1);
        do_update(6'h00, 1'b1, 1'b0);
        do_update(6'h00, 1'b1, 1'b0);
        #1;
        check_value("train.perf3", bus.perf_mispred_o, 32'd3);
        do_update(6'h00, 1'b0, 1'b1);
        apply_stimulus(enc_b(16), 32'h0000_0100);
        check_value("sat_hi.result", {31'd0, bus.bp_result_o}, 32'd1);
        check_value("sat_hi.perf4", bus.perf_mispred_o, 32'd4);
        do_update(6'h00, 1'b0, 1'b0);
        apply_stimulus(enc_b(16), 32'h0000_0100);
        check_value("sat_hi.down2", {31'd0, bus.bp_result_o}, 32'd0);
        check_value("no_mispred.perf", bus.perf_mispred_o, 32'd4);

        // Floor saturation at index 1 and aliasing with index 0.
        do_reset();
        do_update(6'h01, 1'b0, 1'b0);
        do_update(6'h01, 1'b0, 1'b0);
        apply_stimulus(enc_b(16), 32'h0000_0104);
        check_output("sat_lo", 1'b0, 32'h0000_0114, 6'h01);
        apply_stimulus(enc_b(16), 32'h0000_0200);
        check_output("alias0", 1'b0, 32'h0000_0210, 6'h00);
        do_update(6'h01, 1'b1, 1'b1);
        apply_stimulus(enc_b(16), 32'h0000_0104);
        check_value("sat_lo.up1", {31'd0, bus.bp_result_o}, 32'd0);
        do_update(6'h01, 1'b1, 1'b1);
        apply_stimulus(enc_b(16), 32'h0000_0104);
        check_value("sat_lo.up2", {31'd0, bus.bp_result_o}, 32'd1);
        apply_stimulus(enc_b(16), 32'h0000_0200);
        check_value("alias0.after", {31'd0, bus.bp_result_o}, 32'd0);
        check_value("sat_lo.perf", bus.perf_mispred_o, 32'd0);

        // Same-cycle update and predict on one index: no bypass.
        do_reset();
        @(negedge clk);
        bus.inst_i      = enc_b(16);
        bus.inst_addr_i = 32'h0000_0100;
        bus.upd_valid_i = 1'b1;
        bus.upd_index_i = 6'h00;
        bus.upd_taken_i = 1'b1;
        bus.upd_pred_i  = 1'b0;
        #1;
        check_value("same_cycle.now", {31'd0, bus.bp_result_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.upd_valid_i = 1'b0;
        #1;
        check_value("same_cycle.next", {31'd0, bus.bp_result_o}, 32'd1);
`else
        // History register steers the index.
        do_reset();
        do_update(6'h05, 1'b1, 1'b0);
        do_update(6'h05, 1'b1, 1'b0);
        apply_stimulus(enc_b(16), 32'h0000_0100);
        check_output("gshare.idx", 1'b0, 32'h0000_0110, 6'h03);
        check_value("gshare.perf", bus.perf_mispred_o, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_value("gshare.rst_idx", {26'd0, bus.bp_index_o}, 32'd0);
        check_value("gshare.rst_perf", bus.perf_mispred_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
`endif

        // Asynchronous reset mid-cycle discards an in-flight update.
        do_reset();
        do_update(6'h00, 1'b1, 1'b0);
        @(negedge clk);
        bus.inst_i      = enc_b(16);
        bus.inst_addr_i = 32'h0000_0100;
        #1;
        check_value("async.pre_perf", bus.perf_mispred_o, 32'd1);
        bus.upd_valid_i = 1'b1;
        bus.upd_index_i = 6'h00;
        bus.upd_taken_i = 1'b1;
        bus.upd_pred_i  = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_value("async.perf_now", bus.perf_mispred_o, 32'd0);
        check_output("async.pred_now", 1'b0, 32'h0000_0110, 6'h00);
        @(posedge clk);
        #1;
        check_value("async.perf_edge", bus.perf_mispred_o, 32'd0);
        check_value("async.pred_edge", {31'd0, bus.bp_result_o}, 32'd0);
        @(negedge clk);
        bus.upd_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_value("async.after_perf", bus.perf_mispred_o, 32'd0);
        check_output("async.after_pred", 1'b0, 32'h0000_0110, 6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bpu_bimodal.md
Name: bpu_bimodal

Overview:
- Parametrised successor to the single-counter branch predictor in the IF stage.
- Holds a PC-indexed table of ENTRIES saturating counters instead of one shared counter.
- Predicts taken/not-taken and target for the instruction being fetched; trains from EX-stage branch resolution.
- Adds a global misprediction performance counter.

Parameters:
- ENTRIES, 64, number of counter entries; power of two, 2..1024. IDX_W = log2(ENTRIES).
- CNT_W, 2, saturating counter width, 1..4. Taken threshold TH = 2^(CNT_W-1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- inst_i  in  32  fetched instruction
- inst_addr_i  in  32  PC of inst_i
- bp_result_o  out  1  predicted jump
- bp_jump_addr_o  out  32  predicted target
- bp_index_o  out  IDX_W  table index used for this prediction; carried down the pipe
- upd_valid_i  in  1  EX resolved a conditional branch this cycle
- upd_index_i  in  IDX_W  index returned from bp_index_o of that branch
- upd_taken_i  in  1  actual outcome
- upd_pred_i  in  1  prediction originally made for that branch
- perf_mispred_o  out  32  misprediction count

Behaviour:
- Reset (rst low, asynchronous): every counter = TH-1 (weakly not taken; 0 when CNT_W=1); GHR = 0; perf_mispred_o = 0.
- Index: IDX = inst_addr_i[IDX_W+1:2]; with the feature enabled it is XORed with the GHR. bp_index_o = IDX, combinational.
- Prediction: combinational, zero latency, same cycle as inst_i.
  - INST_JAL: target = inst_addr_i + sign-extended J-immediate; bp_result_o = 1 (static; JAL never uses the table).
  - INST_TYPE_B: target = inst_addr_i + sign-extended B-immediate; bp_result_o = (counter[IDX] >= TH).
  - Any other opcode: bp_result_o = 0, bp_jump_addr_o = 0.
  - Target add is 32-bit modular and wraps silently.
- Update, on posedge clk when upd_valid_i=1:
  - counter[upd_index_i] increments if upd_taken_i=1, else decrements.
  - Counter saturates at 2^CNT_W-1 and at 0; no wrap.
  - JAL must not be reported on the update port.
- Predict/update on the same index in one cycle: the prediction uses the pre-update value. No bypass.
- perf_mispred_o increments by 1 when upd_valid_i=1 and upd_taken_i != upd_pred_i; saturates at 32'hFFFFFFFF.
- upd_valid_i=0: table, GHR and perf counter hold.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight update is discarded.
- Flush does not affect the table; stale bp_index_o values for squashed instructions are never sent back on the update port.

Optional Feature:
- Macro BPU_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register GHR.
  - On each update: GHR <= {GHR[IDX_W-2:0], upd_taken_i}.
  - IDX = inst_addr_i[IDX_W+1:2] ^ GHR.
  - GHR is speculative-free: written only from resolved outcomes.
- Undefined: no GHR is instantiated; IDX is PC bits only.

Decomposition:
- Shared defines (existing header): INST_JAL, INST_TYPE_B, JumpDisable, ZeroWord, InstBus, InstAddrBus.
- Add to the header: BPU_CNT_TAKEN_INIT helper constant.
- One sub-module: bpu_sat_counter (CNT_W parameter; inputs en, inc; output value). It is instantiated ENTRIES times via generate.
- Immediate decode and prediction logic stay in the top module.

Test Plan:
- Reset, then B-type beq at PC 0x100 with offset +16 -> bp_result_o=0, bp_jump_addr_o=0x110, bp_index_o=0x00 (ENTRIES=64), perf=0.
- Three taken updates to index 0x00 (upd_pred_i=0), then re-present the same beq -> first update lifts the counter 1->2 and prediction flips to taken; perf_mispred_o=3; counter saturates at 3 after the third update.
- Two not-taken updates to index 0x01 from reset, then a branch at PC 0x104 -> counter stays 0, prediction 0; index 0x00 is unaffected (aliasing check with PC 0x200 -> index 0x00).
- JAL at PC 0xFFFFFFF0 with offset +0x20 -> bp_result_o=1, target 0x00000010 (wrap); table unchanged.
- Update and predict on the same index in the same cycle, counter=1 and upd_taken=1 -> this cycle predicts 0, next cycle predicts 1.
- BPU_GSHARE_EN defined: updates taken,taken -> GHR=0b11; branch at PC 0x100 -> bp_index_o=0x03. Assert rst mid-stream -> GHR=0, perf=0 asynchronously.
